alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised successor to the pipeline's single-cycle ALU: the same `aluc` operation set at configurable `WIDTH`, plus an iterative unsigned multiply/divide unit. The block sits in the EX stage. A valid/ready handshake on both sides lets the hazard unit stall the pipe while a multi-cycle operation runs. Every result comes from a register; no combinational path runs from operands to `rdata`.

## Interface
- `WIDTH`, 32: operand and result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, do not override.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. One clock domain.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block accepts a request this cycle.
- `data1` in WIDTH: operand A; supplies the shift amount for shift ops.
- `data2` in WIDTH: operand B; the shifted value for shift ops.
- `aluc` in 5: operation code.
- `out_valid` out 1: `rdata` holds a result.
- `out_ready` in 1: consumer takes the result.
- `rdata` out WIDTH: result register.
- `busy` out 1: a multiply/divide iteration is in progress.

## Operation
- Request is accepted when `in_valid && in_ready`. The operands and `aluc` are captured on that edge.
- Single-cycle codes:
  - 1, 10, 14, 15: add
  - 2: sub
  - 3, 11: and
  - 4, 12: or
  - 5, 13: xor
  - 6: `data2 << data1[SHW-1:0]`
  - 7: logical right shift
  - 8: arithmetic right shift, sign-extended from `data2[WIDTH-1]`
  - 18: `data2 << (WIDTH/2)`
- Multi-cycle codes:
  - 19: MUL, low WIDTH bits of the unsigned product
  - 20: MULHU, high WIDTH bits of the unsigned product
  - 21: DIVU
  - 22: REMU
- Any other code, including 16/17 (branch compare lives in ID): result 0, single-cycle.
- Add/sub wrap modulo 2^WIDTH. No flags.
- State machine, reset state IDLE:
  - IDLE: on accept, go to MUL or DIV for codes 19–22. For all other codes, write `rdata` and go to DONE.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH iterations, 2·WIDTH accumulator. Then write `rdata` and go to DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH iterations. Then go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE, or accept a new request in the same cycle (see `in_ready`).
- `in_ready` = IDLE || (DONE && `out_ready`). This allows back-to-back single-cycle throughput of 1/cycle.
- Divide by zero: skip iteration and go to DONE next cycle. DIVU result is all ones; REMU result is `data1`.
- `in_valid` while not ready is ignored. Requests are never queued.
- `rdata` holds its value until the next result is written. Its value is undefined in the protocol sense while `out_valid`=0, but it is deterministic.

## Timing
- Reset values: state IDLE, `rdata`=0, `out_valid`=0, `busy`=0, `in_ready`=1. Iteration counter and accumulators are 0.
- Single-cycle op accepted at edge N: `out_valid`=1 after edge N+1.
- MUL/MULHU/DIVU/REMU accepted at edge N: `busy`=1 from N+1 through N+WIDTH. Result and `out_valid` appear after edge N+WIDTH+1.
- Divide by zero: `out_valid` after edge N+1.
- `out_ready` low in DONE: all outputs held stable indefinitely.
- `rst` asserted mid-iteration: immediate return to reset values. No partial result is emitted.

## Configuration
- `ALU_MDU_DIV_EN` defined: DIV datapath present; codes 21/22 behave as specified.
- `ALU_MDU_DIV_EN` undefined: no divider logic and no DIV state. Codes 21/22 decode as unknown, giving a single-cycle result of 0. MUL is unaffected.

## Structure
- Package `alu_pkg`: localparams for all `aluc` codes (`ALUC_ADD` … `ALUC_REMU`) and the state encoding typedef (`IDLE`, `MUL`, `DIV`, `DONE`).
- Sub-module `alu_mdu_iter`: iterative multiply/divide engine.
  - Inputs: `start`, `op`, operands.
  - Outputs: `done` pulse, product/quotient/remainder.
  - Owns the counter and accumulators.
- Top level holds the single-cycle datapath, handshake and result register.

## Test plan
- WIDTH=32: back-to-back add `0xFFFFFFFF+1`, then sub `0-1`, with `out_ready`=1.
  - Results 0 then `0xFFFFFFFF` on consecutive cycles; `in_ready` never drops.
- SRA `data2=0x80000000`, `data1=4`: `0xF8000000`. SRL same operands: `0x08000000`. LUI `data2=0x1234`: `0x12340000`.
- MUL `0xFFFFFFFF×0xFFFFFFFF`: low word `0x00000001`; MULHU gives `0xFFFFFFFE`.
  - `out_valid` exactly 33 cycles after accept; `in_ready`=0 throughout.
- DIVU `100/7` gives 14; REMU gives 2. DIVU `5/0` gives `0xFFFFFFFF` after 1 cycle. REMU `5/0` gives 5.
- Hold `out_ready`=0 for 10 cycles in DONE: `rdata`/`out_valid` stable; a new `in_valid` is ignored.
- Assert `rst` at iteration 10 of a MUL: all outputs at reset values immediately. A following add `3+4` gives 7 with single-cycle latency.
- Without `ALU_MDU_DIV_EN`: DIVU `100/7` gives 0 after 1 cycle; `busy` is never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_mdu shared definitions: aluc operation codes and FSM state encoding.
// Optional divider datapath is enabled by defining ALU_MDU_DIV_EN.
package alu_pkg;

    localparam logic [4:0] ALUC_ADD   = 5'd1;
    localparam logic [4:0] ALUC_SUB   = 5'd2;
    localparam logic [4:0] ALUC_AND   = 5'd3;
    localparam logic [4:0] ALUC_OR    = 5'd4;
    localparam logic [4:0] ALUC_XOR   = 5'd5;
    localparam logic [4:0] ALUC_SLL   = 5'd6;
    localparam logic [4:0] ALUC_SRL   = 5'd7;
    localparam logic [4:0] ALUC_SRA   = 5'd8;
    localparam logic [4:0] ALUC_ADD2  = 5'd10;
    localparam logic [4:0] ALUC_AND2  = 5'd11;
    localparam logic [4:0] ALUC_OR2   = 5'd12;
    localparam logic [4:0] ALUC_XOR2  = 5'd13;
    localparam logic [4:0] ALUC_ADD3  = 5'd14;
    localparam logic [4:0] ALUC_ADD4  = 5'd15;
    localparam logic [4:0] ALUC_LUI   = 5'd18;
    localparam logic [4:0] ALUC_MUL   = 5'd19;
    localparam logic [4:0] ALUC_MULHU = 5'd20;
    localparam logic [4:0] ALUC_DIVU  = 5'd21;
    localparam logic [4:0] ALUC_REMU  = 5'd22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_MDU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Request/result handshake bundle between the EX-stage control and alu_mdu.
interface alu_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [4:0]       aluc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    modport master (
        output in_valid, data1, data2, aluc, out_ready,
        input  in_ready, out_valid, rdata, busy
    );

    modport slave (
        input  in_valid, data1, data2, aluc, out_ready,
        output in_ready, out_valid, rdata, busy
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply (shift-add) and, with ALU_MDU_DIV_EN, restoring
// divide. One bit per cycle for WIDTH cycles; done_c and the result outputs
// reflect the final iteration during the cycle it is being computed.
module alu_mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_MDU_DIV_EN
    input  logic             op_div,
`endif
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             done_c,
    output logic [WIDTH-1:0] res_lo_c,
    output logic [WIDTH-1:0] res_hi_c
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, step_c;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               active_q, active_d;
    logic [WIDTH:0]     mul_sum_c;
`ifdef ALU_MDU_DIV_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     r_shift_c, diff_c;
    logic [WIDTH-1:0]   rem_c;
    logic               quo_bit_c;
`endif

    // One iteration step; acc holds {hi, lo} = {partial/remainder, multiplier/quotient}
    always_comb begin
        mul_sum_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        step_c    = {mul_sum_c, acc_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        r_shift_c = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_c    = r_shift_c - {1'b0, opb_q};
        quo_bit_c = ~diff_c[WIDTH];
        rem_c     = quo_bit_c ? diff_c[WIDTH-1:0] : r_shift_c[WIDTH-1:0];
        if (div_q) begin
            step_c = {rem_c, acc_q[WIDTH-2:0], quo_bit_c};
        end
`endif
    end

    // Counter/accumulator sequencing: load on start, iterate while active
    always_comb begin
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        active_d = active_q;
`ifdef ALU_MDU_DIV_EN
        div_d    = div_q;
`endif
        done_c   = active_q && (cnt_q == CW'(WIDTH - 1));
        if (active_q) begin
            acc_d = step_c;
            cnt_d = cnt_q + CW'(1);
            if (done_c) begin
                active_d = 1'b0;
            end
        end
        if (start) begin
            acc_d    = {{WIDTH{1'b0}}, opa};
            opb_d    = opb;
            cnt_d    = '0;
            active_d = 1'b1;
`ifdef ALU_MDU_DIV_EN
            div_d    = op_div;
`endif
        end
    end

    assign res_lo_c = step_c[WIDTH-1:0];
    assign res_hi_c = step_c[2*WIDTH-1:WIDTH];

    // Engine state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
`ifdef ALU_MDU_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative unsigned multiply/divide and valid/ready handshake.
// Define ALU_MDU_DIV_EN to include the divider (codes 21/22); otherwise those
// codes decode as unknown and return 0 in a single cycle.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mdu_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             sel_hi_q, sel_hi_d;

    logic             in_ready_c, accept_c, start_c, is_mul_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             iter_done_c;
    logic [WIDTH-1:0] iter_lo_c, iter_hi_c;
`ifdef ALU_MDU_DIV_EN
    logic             is_div_c, div_zero_c;

    assign is_div_c   = (bus.aluc == ALUC_DIVU) || (bus.aluc == ALUC_REMU);
    assign div_zero_c = (bus.data2 == '0);
`endif

    assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign is_mul_c   = (bus.aluc == ALUC_MUL) || (bus.aluc == ALUC_MULHU);
    assign shamt_c    = bus.data1[SHW-1:0];

    // Single-cycle datapath; unknown codes return 0
    always_comb begin
        alu_res_c = '0;
        case (bus.aluc)
            ALUC_ADD, ALUC_ADD2, ALUC_ADD3, ALUC_ADD4: alu_res_c = bus.data1 + bus.data2;
            ALUC_SUB:              alu_res_c = bus.data1 - bus.data2;
            ALUC_AND, ALUC_AND2:   alu_res_c = bus.data1 & bus.data2;
            ALUC_OR,  ALUC_OR2:    alu_res_c = bus.data1 | bus.data2;
            ALUC_XOR, ALUC_XOR2:   alu_res_c = bus.data1 ^ bus.data2;
            ALUC_SLL:              alu_res_c = bus.data2 << shamt_c;
            ALUC_SRL:              alu_res_c = bus.data2 >> shamt_c;
            ALUC_SRA:              alu_res_c = WIDTH'($signed(bus.data2) >>> shamt_c);
            ALUC_LUI:              alu_res_c = bus.data2 << (WIDTH / 2);
            ALUC_MUL, ALUC_MULHU, ALUC_DIVU, ALUC_REMU: alu_res_c = '0;
            default:               alu_res_c = '0;
        endcase
    end

    alu_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
`ifdef ALU_MDU_DIV_EN
        .op_div   (is_div_c),
`endif
        .opa      (bus.data1),
        .opb      (bus.data2),
        .done_c   (iter_done_c),
        .res_lo_c (iter_lo_c),
        .res_hi_c (iter_hi_c)
    );

    // Next-state and result-register logic; a new accept overrides DONE draining
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        sel_hi_d    = sel_hi_q;
        start_c     = 1'b0;
        if ((state_q == DONE) && bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
        if (iter_done_c) begin
            rdata_d     = sel_hi_q ? iter_hi_c : iter_lo_c;
            state_d     = DONE;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
        end
        if (accept_c) begin
            if (is_mul_c) begin
                sel_hi_d    = (bus.aluc == ALUC_MULHU);
                state_d     = MUL;
                busy_d      = 1'b1;
                out_valid_d = 1'b0;
                start_c     = 1'b1;
            end
`ifdef ALU_MDU_DIV_EN
            else if (is_div_c) begin
                sel_hi_d = (bus.aluc == ALUC_REMU);
                if (div_zero_c) begin
                    rdata_d     = (bus.aluc == ALUC_DIVU) ? '1 : bus.data1;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = DIV;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                    start_c     = 1'b1;
                end
            end
`endif
            else begin
                rdata_d     = alu_res_c;
                state_d     = DONE;
                out_valid_d = 1'b1;
            end
        end
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sel_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sel_hi_q    <= sel_hi_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32); expectations follow ALU_MDU_DIV_EN.
module tb_alu_mdu;
    localparam int unsigned W = 32;
`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference result computed from the operation definitions
    function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] ext;
        int             sh;
        prod = {32'd0, a} * {32'd0, b};
        ext  = {{W{b[W-1]}}, b};
        sh   = int'(a[4:0]);
        case (op)
            5'd1, 5'd10, 5'd14, 5'd15: return a + b;
            5'd2:         return a - b;
            5'd3, 5'd11:  return a & b;
            5'd4, 5'd12:  return a | b;
            5'd5, 5'd13:  return a ^ b;
            5'd6:         return b << sh;
            5'd7:         return b >> sh;
            5'd8:         begin ext = ext >> sh; return ext[W-1:0]; end
            5'd18:        return W'(b * 32'd65536);
            5'd19:        return prod[W-1:0];
            5'd20:        return prod[2*W-1:W];
            5'd21:        return !DIV_EN ? '0 : (b == 0) ? '1 : a / b;
            5'd22:        return !DIV_EN ? '0 : (b == 0) ? a : a % b;
            default:      return '0;
        endcase
    endfunction

    // Cycles from the accept cycle until out_valid is first seen
    function automatic int ref_latency(input logic [4:0] op, input logic [W-1:0] b);
        if (op == 5'd19 || op == 5'd20) return W + 1;
        if (DIV_EN && (op == 5'd21 || op == 5'd22) && b != 0) return W + 1;
        return 1;
    endfunction

    // Issue one request and wait for its result; reports latency and busy/in_ready samples
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat, output int bcnt,
                          output int ir_low, output logic busy_at_done);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.aluc     = op;
        bus.data1    = a;
        bus.data2    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.data1    = $urandom;
        bus.data2    = $urandom;
        bus.aluc     = 5'($urandom);
        lat = 1; bcnt = 0; ir_low = 0;
        while (!bus.out_valid && lat < 64) begin
            if (bus.busy) bcnt++;
            if (!bus.in_ready) ir_low++;
            @(posedge clk); #1;
            lat++;
        end
        res          = bus.rdata;
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h required 0", bus.rdata); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1; bus.aluc = 5'd1; bus.data1 = 32'hFFFF_FFFF; bus.data2 = 32'd1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b required 1", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.rdata !== 32'd0) begin
            errors++; $display("FAIL b2b_add: got valid=%b rdata=%h required valid=1 rdata=00000000", bus.out_valid, bus.rdata); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b required 1", bus.in_ready); end
        bus.aluc = 5'd2; bus.data1 = 32'd0; bus.data2 = 32'd1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL b2b_sub: got valid=%b rdata=%h required valid=1 rdata=ffffffff", bus.out_valid, bus.rdata); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b required 1", bus.in_ready); end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b required 0", bus.out_valid); end
    endtask

    task automatic test_shifts();
        logic [W-1:0] res; int lat, bc, irl; logic bd;
        logic [4:0]   ops  [3] = '{5'd8, 5'd7, 5'd18};
        logic [W-1:0] as   [3] = '{32'd4, 32'd4, 32'd0};
        logic [W-1:0] bs   [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
        logic [W-1:0] exps [3] = '{32'hF800_0000, 32'h0800_0000, 32'h1234_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bc, irl, bd);
            checks++; if (res !== exps[i] || lat != 1) begin
                errors++; $display("FAIL shift_op%0d: got %h lat %0d required %h lat 1", ops[i], res, lat, exps[i]); end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] res; int lat, bc, irl; logic bd;
        run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc, irl, bd);
        checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL mul_lo: got %h required 00000001", res); end
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d required 33", lat); end
        checks++; if (bc != 32 || irl != 32 || bd !== 1'b0) begin
            errors++; $display("FAIL mul_busy: got busy=%0d ready_low=%0d busy_done=%b required 32 32 0", bc, irl, bd); end
        run_op(5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc, irl, bd);
        checks++; if (res !== 32'hFFFF_FFFE || lat != 33) begin
            errors++; $display("FAIL mulhu: got %h lat %0d required fffffffe lat 33", res, lat); end
    endtask

    task automatic test_div();
        logic [W-1:0] res; int lat, bc, irl; logic bd;
        run_op(5'd21, 32'd100, 32'd7, res, lat, bc, irl, bd);
        checks++; if (res !== (DIV_EN ? 32'd14 : 32'd0) || lat != (DIV_EN ? 33 : 1)) begin
            errors++; $display("FAIL divu: got %h lat %0d required %h lat %0d", res, lat, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1); end
        checks++; if (bc != (DIV_EN ? 32 : 0)) begin errors++; $display("FAIL divu_busy: got %0d required %0d", bc, DIV_EN ? 32 : 0); end
        run_op(5'd22, 32'd100, 32'd7, res, lat, bc, irl, bd);
        checks++; if (res !== (DIV_EN ? 32'd2 : 32'd0)) begin
            errors++; $display("FAIL remu: got %h required %h", res, DIV_EN ? 32'd2 : 32'd0); end
        run_op(5'd21, 32'd5, 32'd0, res, lat, bc, irl, bd);
        checks++; if (res !== (DIV_EN ? 32'hFFFF_FFFF : 32'd0) || lat != 1 || bc != 0) begin
            errors++; $display("FAIL divu_zero: got %h lat %0d busy %0d required %h lat 1 busy 0", res, lat, bc, DIV_EN ? 32'hFFFF_FFFF : 32'd0); end
        run_op(5'd22, 32'd5, 32'd0, res, lat, bc, irl, bd);
        checks++; if (res !== (DIV_EN ? 32'd5 : 32'd0) || lat != 1) begin
            errors++; $display("FAIL remu_zero: got %h lat %0d required %h lat 1", res, lat, DIV_EN ? 32'd5 : 32'd0); end
    endtask

    task automatic test_hold();
        logic [W-1:0] res, a, b, exp_r; int lat, bc, irl; logic bd;
        int bad = 0;
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        exp_r = ref_result(5'd20, a, b);
        bus.out_ready = 1'b0;
        run_op(5'd20, a, b, res, lat, bc, irl, bd);
        checks++; if (res !== exp_r) begin errors++; $display("FAIL hold_result: got %h required %h", res, exp_r); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.aluc = 5'd1; bus.data1 = $urandom; bus.data2 = $urandom;
            if (bus.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            if (bus.rdata !== exp_r || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable samples required 0", bad); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.rdata !== exp_r) begin
            errors++; $display("FAIL hold_release: got valid=%b rdata=%h required valid=0 rdata=%h", bus.out_valid, bus.rdata, exp_r); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res; int lat, bc, irl; logic bd;
        int stray = 0;
        bus.in_valid = 1'b1; bus.aluc = 5'd19; bus.data1 = $urandom | 32'h1; bus.data2 = $urandom | 32'h1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", bus.busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.rdata !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: got rdata=%h valid=%b busy=%b ready=%b required 0 0 0 1",
                               bus.rdata, bus.out_valid, bus.busy, bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_partial: got %0d active samples required 0", stray); end
        run_op(5'd1, 32'd3, 32'd4, res, lat, bc, irl, bd);
        checks++; if (res !== 32'd7 || lat != 1) begin
            errors++; $display("FAIL mid_add: got %h lat %0d required 00000007 lat 1", res, lat); end
    endtask

    task automatic test_random();
        logic [4:0]   tbl [20] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 5'd11,
                                   5'd12, 5'd13, 5'd14, 5'd15, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd16};
        logic [4:0]   op;
        logic [W-1:0] a, b, res, exp_r;
        int           lat, bc, irl, exp_l;
        logic         bd;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 4) != 0) ? tbl[$urandom_range(0, 19)] : 5'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) a = a & 32'h3F;
            exp_r = ref_result(op, a, b);
            exp_l = ref_latency(op, b);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            run_op(op, a, b, res, lat, bc, irl, bd);
            checks++; if (res !== exp_r || lat != exp_l) begin
                errors++; $display("FAIL rand_op%0d a=%h b=%h: got %h lat %0d required %h lat %0d", op, a, b, res, lat, exp_r, exp_l); end
            checks++; if (bc != exp_l - 1 || irl != exp_l - 1 || bd !== 1'b0) begin
                errors++; $display("FAIL rand_busy_op%0d: got busy=%0d ready_low=%0d busy_done=%b required %0d %0d 0", op, bc, irl, bd, exp_l - 1, exp_l - 1); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.aluc      = 5'd0;
        bus.data1     = '0;
        bus.data2     = '0;
        test_reset();
        test_back_to_back();
        test_shifts();
        test_mul();
        test_div();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
